// File: rtl/aes256_inv_key_sched.sv
// AES-256 decryption-side key scheduler: expands forward to the last window, then streams RK14..RK0.
// Optional macro AES_INV_KEY_EQINV_EN emits InvMixColumns'd RK13..RK1 (equivalent inverse cipher keys).
module aes256_inv_key_sched #(
  parameter int NUM_RK = 15,
  parameter int IDX_W  = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [0:255]     key_i,
  input  logic             key_v_i,
  output logic             key_ready_o,
  output logic [0:127]     rk_o,
  output logic [IDX_W-1:0] rk_idx_o,
  output logic             rk_v_o,
  input  logic             rk_ready_i,
  output logic             rk_last_o
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXPAND = 2'd1, ST_EMIT = 2'd2} state_t;
  typedef logic [0:7][31:0] win_t;

  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_RK - 1);
  localparam logic [3:0]       R_DONE  = 4'd8;

  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rcon_word(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

  // S_{r-1} -> S_r: the existing forward round_key step.
  function automatic win_t fwd_round(input win_t s, input logic [3:0] r);
    win_t n;
    n[0] = s[0] ^ sub_word({s[7][23:0], s[7][31:24]}) ^ rcon_word(r);
    n[1] = s[1] ^ n[0];
    n[2] = s[2] ^ n[1];
    n[3] = s[3] ^ n[2];
    n[4] = s[4] ^ sub_word(n[3]);
    n[5] = s[5] ^ n[4];
    n[6] = s[6] ^ n[5];
    n[7] = s[7] ^ n[6];
    return n;
  endfunction

  // S_r -> S_{r-1}; word 0 depends on the freshly recovered word 7.
  function automatic win_t inv_round(input win_t s, input logic [3:0] r);
    win_t n;
    n[7] = s[7] ^ s[6];
    n[6] = s[6] ^ s[5];
    n[5] = s[5] ^ s[4];
    n[4] = s[4] ^ sub_word(s[3]);
    n[3] = s[3] ^ s[2];
    n[2] = s[2] ^ s[1];
    n[1] = s[1] ^ s[0];
    n[0] = s[0] ^ sub_word({n[7][23:0], n[7][31:24]}) ^ rcon_word(r);
    return n;
  endfunction

`ifdef AES_INV_KEY_EQINV_EN
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    a[0] = c[31:24];
    a[1] = c[23:16];
    a[2] = c[15:8];
    a[3] = c[7:0];
    for (int k = 0; k < 4; k++) begin
      x2     = xt(a[k]);
      x4     = xt(x2);
      x8     = xt(x4);
      m9[k]  = x8 ^ a[k];
      m11[k] = x8 ^ x2 ^ a[k];
      m13[k] = x8 ^ x4 ^ a[k];
      m14[k] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

  function automatic logic [0:127] inv_mix(input logic [0:127] b);
    return {inv_mix_col(b[0:31]), inv_mix_col(b[32:63]),
            inv_mix_col(b[64:95]), inv_mix_col(b[96:127])};
  endfunction
`endif

  state_t           state_q, state_d;
  win_t             s_q, s_d;
  logic [3:0]       r_q, r_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             emit_s;
  logic [0:127]     rk_raw_s;

  // Next state: load key, expand forward to S7, then step back one window after each even beat.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    r_d     = r_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (key_v_i) begin
          s_d     = key_i;
          r_d     = 4'd1;
          state_d = ST_EXPAND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXPAND: begin
        if (r_q == R_DONE) begin
          r_d     = 4'd7;
          idx_d   = IDX_TOP;
          state_d = ST_EMIT;
        end else begin
          s_d = fwd_round(s_q, r_q);
          r_d = r_q + 4'd1;
        end
      end
      ST_EMIT: begin
        if (!rk_ready_i) begin
          state_d = ST_EMIT;
        end else if (idx_q == '0) begin
          state_d = ST_IDLE;
        end else if (!idx_q[0]) begin
          s_d   = inv_round(s_q, r_q);
          r_d   = r_q - 4'd1;
          idx_d = idx_q - IDX_W'(1);
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, schedule window, round counter and key index.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      r_q     <= 4'd0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      r_q     <= r_d;
      idx_q   <= idx_d;
    end
  end

  assign emit_s   = (state_q == ST_EMIT);
  assign rk_raw_s = idx_q[0] ? s_q[4:7] : s_q[0:3];

  // Output key mux; zero whenever no beat is being offered.
  always_comb begin
    rk_o = '0;
    if (emit_s) begin
`ifdef AES_INV_KEY_EQINV_EN
      if ((idx_q != '0) && (idx_q != IDX_TOP)) begin
        rk_o = inv_mix(rk_raw_s);
      end else begin
        rk_o = rk_raw_s;
      end
`else
      rk_o = rk_raw_s;
`endif
    end else begin
      rk_o = '0;
    end
  end

  assign key_ready_o = reset_n_i & (state_q == ST_IDLE);
  assign rk_v_o      = emit_s;
  assign rk_idx_o    = emit_s ? idx_q : '0;
  assign rk_last_o   = emit_s & (idx_q == '0);

endmodule

// File: tb/tb_aes256_inv_key_sched.sv
// Bench for aes256_inv_key_sched: FIPS-197 known-answer table plus random keys checked
// against a plain FIPS-197 key expansion with an arithmetically derived S-box.
`timescale 1ns/1ps
module tb_aes256_inv_key_sched;

  typedef struct {
    logic [0:255] key;
    logic [0:127] rk14;
    logic [0:127] rk1;
    logic [0:127] rk0;
  } kat_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [0:255] key;
  logic         key_v;
  logic         key_ready;
  logic [0:127] rk;
  logic [3:0]   rk_idx;
  logic         rk_v;
  logic         rk_ready;
  logic         rk_last;

  int checks = 0;
  int errors = 0;
  logic [7:0]   sb [256];
  logic [0:127] mdl_rk [15];
  logic [0:127] got_rk [15];
  kat_t         kat [2];

  always #5 clk = ~clk;

  aes256_inv_key_sched dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .key_i       (key),
    .key_v_i     (key_v),
    .key_ready_o (key_ready),
    .rk_o        (rk),
    .rk_idx_o    (rk_idx),
    .rk_v_o      (rk_v),
    .rk_ready_i  (rk_ready),
    .rk_last_o   (rk_last)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk128(input string name, input logic [0:127] act, input logic [0:127] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic model_schedule(input logic [0:255] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = k[32*i +: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int n = 0; n < 15; n++) mdl_rk[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endtask

  function automatic logic [0:127] inv_mix_model(input logic [0:127] b);
    logic [7:0]   coef [4];
    logic [0:127] o;
    logic [7:0]   acc;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - r + 4) % 4], b[8*(4*c+k) +: 8]);
        o[8*(4*c+r) +: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [0:127] exp_beat(input int n);
`ifdef AES_INV_KEY_EQINV_EN
    if (n != 0 && n != 14) return inv_mix_model(mdl_rk[n]);
`endif
    return mdl_rk[n];
  endfunction

  // Handshake a key and check the expansion latency; returns at the first valid beat.
  task automatic start_key(input logic [0:255] k, input bit busy);
    @(negedge clk);
    key = k; key_v = 1'b1;
    chk1("key_ready_idle", key_ready, 1'b1);
    @(negedge clk);
    key = '0; key_v = 1'b0;
    for (int m = 1; m <= 8; m++) begin
      @(negedge clk);
      if (m == 3) begin
        chk1("key_ready_busy_expand", key_ready, 1'b0);
        key_v = busy;
      end else begin
        key_v = 1'b0;
      end
      if (m == 7) chk1("rk_v_early", rk_v, 1'b0);
      if (m == 8) chk1("rk_v_latency", rk_v, 1'b1);
    end
  endtask

  task automatic stream_key(input bit rand_ready, input bit busy);
    logic [0:127] hold_rk;
    logic [3:0]   hold_idx;
    bit           stalled;
    int           beats, cyc;
    beats = 0; cyc = 0; stalled = 1'b0;
    hold_rk = '0; hold_idx = 4'd0;
    while (beats < 15 && cyc < 300) begin
      rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      key_v = busy && (cyc == 2);
      if (busy && cyc == 2) chk1("key_ready_busy_emit", key_ready, 1'b0);
      chk1("rk_v_stream", rk_v, 1'b1);
      if (stalled) begin
        chk128("stall_hold_rk", rk, hold_rk);
        chk4("stall_hold_idx", rk_idx, hold_idx);
      end
      if (rk_ready) begin
        chk4("beat_idx", rk_idx, 4'(14 - beats));
        chk128("beat_rk", rk, exp_beat(14 - beats));
        chk1("beat_last", rk_last, beats == 14);
        got_rk[14 - beats] = rk;
        beats++;
        stalled = 1'b0;
      end else begin
        stalled  = 1'b1;
        hold_rk  = rk;
        hold_idx = rk_idx;
      end
      @(negedge clk);
      cyc++;
    end
    key_v = 1'b0; rk_ready = 1'b0;
    chk4("beat_count", 4'(beats), 4'd15);
    chk1("rk_v_after_last", rk_v, 1'b0);
    chk1("key_ready_after_last", key_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:255] rkey;
    reset_n = 1'b1; key = '0; key_v = 1'b0; rk_ready = 1'b0;
    kat[0].key  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    kat[0].rk14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;
    kat[0].rk1  = 128'h101112131415161718191a1b1c1d1e1f;
    kat[0].rk0  = 128'h000102030405060708090a0b0c0d0e0f;
    kat[1].key  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    kat[1].rk14 = 128'hfe4890d1e6188d0b046df344706c631e;
    kat[1].rk1  = 128'h1f352c073b6108d72d9810a30914dff4;
    kat[1].rk0  = 128'h603deb1015ca71be2b73aef0857d7781;
    build_sbox();
    #2 reset_n = 1'b0;
    #1;
    chk1("reset_key_ready", key_ready, 1'b0);
    chk1("reset_rk_v", rk_v, 1'b0);
    chk128("reset_rk", rk, 128'h0);
    chk4("reset_rk_idx", rk_idx, 4'd0);
    chk1("reset_rk_last", rk_last, 1'b0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    #1 chk1("key_ready_release", key_ready, 1'b1);

    for (int t = 0; t < 2; t++) begin
      model_schedule(kat[t].key);
      start_key(kat[t].key, t == 1);
      stream_key(1'b0, t == 1);
      chk128("kat_rk14", got_rk[14], kat[t].rk14);
`ifndef AES_INV_KEY_EQINV_EN
      chk128("kat_rk1", got_rk[1], kat[t].rk1);
`endif
      chk128("kat_rk0", got_rk[0], kat[t].rk0);
    end

    // Reset in the middle of a stream aborts it; the next key starts again from RK14.
    start_key(kat[1].key, 1'b0);
    rk_ready = 1'b1;
    repeat (3) @(negedge clk);
    rk_ready = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk1("midreset_rk_v", rk_v, 1'b0);
    chk128("midreset_rk", rk, 128'h0);
    chk4("midreset_rk_idx", rk_idx, 4'd0);
    chk1("midreset_rk_last", rk_last, 1'b0);
    chk1("midreset_key_ready", key_ready, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk1("key_ready_after_reset", key_ready, 1'b1);
    model_schedule(kat[0].key);
    start_key(kat[0].key, 1'b0);
    stream_key(1'b0, 1'b0);

    rkey = {32{8'h64}};
    model_schedule(rkey);
    start_key(rkey, 1'b1);
    stream_key(1'b1, 1'b1);

    rkey = '0;
    model_schedule(rkey);
    start_key(rkey, 1'b0);
    stream_key(1'b0, 1'b0);

    for (int n = 0; n < 4; n++) begin
      for (int j = 0; j < 8; j++) rkey[32*j +: 32] = $urandom;
      model_schedule(rkey);
      start_key(rkey, n[0]);
      stream_key(n != 3, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
